// File: rtl/timer_irq_master.sv
// Avalon-MM initiator that programs an interval timer slave, services its timeout IRQ
// as a tick counter, and performs counter snapshot reads and stop sequences on request.
module timer_irq_master #(
  parameter bit ITO_EN  = 1'b1,
  parameter bit SNAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [31:0] cfg_period,
  input  logic        cfg_continuous,
  input  logic        snap_req,
  output logic        busy,
  output logic        tick_pulse,
  output logic [31:0] tick_count,
  output logic [31:0] snapshot,
  output logic        snapshot_valid,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata,
  input  logic        irq_in
);

  localparam logic [2:0] AddrStatus  = 3'd0;
  localparam logic [2:0] AddrControl = 3'd1;
  localparam logic [2:0] AddrPeriodL = 3'd2;
  localparam logic [2:0] AddrPeriodH = 3'd3;
  localparam logic [2:0] AddrSnapL   = 3'd4;
  localparam logic [2:0] AddrSnapH   = 3'd5;

  localparam logic [15:0] CtlStop = 16'h0008;

  typedef enum logic [3:0] {
    StIdle,
    StWrPl,
    StWrPh,
    StWrCtl,
    StRun,
    StClrSt,
    StSnapW,
    StRdL,
    StRdH,
    StCap,
    StStopCtl,
    StStopClr
  } state_e;

  state_e      state_q;
  logic [31:0] period_q;
  logic        cont_q;
  logic        stop_pend_q;
  logic        snap_pend_q;
  logic [31:0] tick_count_q;
  logic [31:0] snapshot_q;
  logic        snapshot_valid_q;
  logic        tick_pulse_q;
  logic [2:0]  addr_q;
  logic        cs_q;
  logic        write_n_q;
  logic [15:0] wdata_q;

  logic        stop_eff;
  logic        snap_eff;
  logic [15:0] ctl_word;

  // A request arriving in the same cycle RUN decides must count, so stop beats a same-cycle irq.
  always_comb begin
    stop_eff = stop_pend_q | cfg_stop;
    snap_eff = snap_pend_q | (SNAP_EN & snap_req);
    ctl_word = {12'h000, 1'b0, 1'b1, cont_q, ITO_EN};
  end

  // Bus outputs are loaded on the edge entering a state, so each access is seen during that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      period_q         <= 32'd0;
      cont_q           <= 1'b0;
      stop_pend_q      <= 1'b0;
      snap_pend_q      <= 1'b0;
      tick_count_q     <= 32'd0;
      snapshot_q       <= 32'd0;
      snapshot_valid_q <= 1'b0;
      tick_pulse_q     <= 1'b0;
      addr_q           <= 3'd0;
      cs_q             <= 1'b0;
      write_n_q        <= 1'b1;
      wdata_q          <= 16'h0000;
    end else begin
      cs_q             <= 1'b0;
      write_n_q        <= 1'b1;
      addr_q           <= 3'd0;
      wdata_q          <= 16'h0000;
      tick_pulse_q     <= 1'b0;
      snapshot_valid_q <= 1'b0;

      if (state_q != StIdle) begin
        if (cfg_stop)           stop_pend_q <= 1'b1;
        if (SNAP_EN && snap_req) snap_pend_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (cfg_start && (cfg_period != 32'd0)) begin
            period_q     <= cfg_period;
            cont_q       <= cfg_continuous;
            tick_count_q <= 32'd0;
            state_q      <= StWrPl;
            cs_q         <= 1'b1;
            write_n_q    <= 1'b0;
            addr_q       <= AddrPeriodL;
            wdata_q      <= cfg_period[15:0];
          end
        end
        StWrPl: begin
          state_q   <= StWrPh;
          cs_q      <= 1'b1;
          write_n_q <= 1'b0;
          addr_q    <= AddrPeriodH;
          wdata_q   <= period_q[31:16];
        end
        StWrPh: begin
          state_q   <= StWrCtl;
          cs_q      <= 1'b1;
          write_n_q <= 1'b0;
          addr_q    <= AddrControl;
          wdata_q   <= ctl_word;
        end
        StWrCtl: begin
          state_q <= StRun;
        end
        StRun: begin
          if (stop_eff) begin
            state_q   <= StStopCtl;
            cs_q      <= 1'b1;
            write_n_q <= 1'b0;
            addr_q    <= AddrControl;
            wdata_q   <= CtlStop;
          end else if (irq_in) begin
            state_q      <= StClrSt;
            cs_q         <= 1'b1;
            write_n_q    <= 1'b0;
            addr_q       <= AddrStatus;
            tick_pulse_q <= 1'b1;
            tick_count_q <= tick_count_q + 32'd1;
          end else if (snap_eff) begin
            state_q   <= StSnapW;
            cs_q      <= 1'b1;
            write_n_q <= 1'b0;
            addr_q    <= AddrSnapL;
          end
        end
        StClrSt: begin
          if (cont_q) begin
            state_q <= StRun;
          end else begin
            state_q     <= StIdle;
            stop_pend_q <= 1'b0;
            snap_pend_q <= 1'b0;
          end
        end
        StSnapW: begin
          state_q <= StRdL;
          cs_q    <= 1'b1;
          addr_q  <= AddrSnapL;
        end
        StRdL: begin
          state_q <= StRdH;
          cs_q    <= 1'b1;
          addr_q  <= AddrSnapH;
        end
        StRdH: begin
          // Read data for snap_l returns during this state.
          snapshot_q[15:0] <= m_readdata;
          state_q          <= StCap;
        end
        StCap: begin
          snapshot_q[31:16] <= m_readdata;
          snapshot_valid_q  <= 1'b1;
          snap_pend_q       <= 1'b0;
          state_q           <= StRun;
        end
        StStopCtl: begin
          state_q   <= StStopClr;
          cs_q      <= 1'b1;
          write_n_q <= 1'b0;
          addr_q    <= AddrStatus;
        end
        StStopClr: begin
          state_q     <= StIdle;
          stop_pend_q <= 1'b0;
          snap_pend_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy           = (state_q != StIdle);
  assign tick_pulse     = tick_pulse_q;
  assign tick_count     = tick_count_q;
  assign snapshot       = snapshot_q;
  assign snapshot_valid = snapshot_valid_q;
  assign m_address      = addr_q;
  assign m_chipselect   = cs_q;
  assign m_write_n      = write_n_q;
  assign m_writedata    = wdata_q;

endmodule

// File: tb/tb_timer_irq_master.sv
// Directed bench for timer_irq_master: programming, tick servicing, snapshot, stop, reset.
module tb_timer_irq_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_start;
  logic        cfg_stop;
  logic [31:0] cfg_period;
  logic        cfg_continuous;
  logic        snap_req;
  logic        busy;
  logic        tick_pulse;
  logic [31:0] tick_count;
  logic [31:0] snapshot;
  logic        snapshot_valid;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata;
  logic        irq_in;

  int n_cmp = 0;
  int n_err = 0;

  timer_irq_master #(
    .ITO_EN (1'b1),
    .SNAP_EN(1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_period    (cfg_period),
    .cfg_continuous(cfg_continuous),
    .snap_req      (snap_req),
    .busy          (busy),
    .tick_pulse    (tick_pulse),
    .tick_count    (tick_count),
    .snapshot      (snapshot),
    .snapshot_valid(snapshot_valid),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .irq_in        (irq_in)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] addr, input logic [15:0] data);
    chk({tag, ".cs"}, 32'(m_chipselect), 32'd1);
    chk({tag, ".wn"}, 32'(m_write_n), 32'd0);
    chk({tag, ".addr"}, 32'(m_address), 32'(addr));
    chk({tag, ".data"}, 32'(m_writedata), 32'(data));
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] addr);
    chk({tag, ".cs"}, 32'(m_chipselect), 32'd1);
    chk({tag, ".wn"}, 32'(m_write_n), 32'd1);
    chk({tag, ".addr"}, 32'(m_address), 32'(addr));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".cs"}, 32'(m_chipselect), 32'd0);
    chk({tag, ".wn"}, 32'(m_write_n), 32'd1);
  endtask

  initial begin
    reset_n        = 1'b0;
    cfg_start      = 1'b0;
    cfg_stop       = 1'b0;
    cfg_period     = 32'd0;
    cfg_continuous = 1'b0;
    snap_req       = 1'b0;
    m_readdata     = 16'h0000;
    irq_in         = 1'b0;
    step();
    step();

    // Reset state
    chk_idle("rst");
    chk("rst.addr", 32'(m_address), 32'd0);
    chk("rst.data", 32'(m_writedata), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.tick", 32'(tick_pulse), 32'd0);
    chk("rst.count", tick_count, 32'd0);
    chk("rst.snap", snapshot, 32'd0);
    chk("rst.snapv", 32'(snapshot_valid), 32'd0);
    reset_n = 1'b1;
    step();

    // Continuous start: three programming writes on consecutive cycles
    cfg_start = 1'b1; cfg_period = 32'h0001_86A0; cfg_continuous = 1'b1;
    step();
    cfg_start = 1'b0;
    chk_wr("c.pl", 3'd2, 16'h86A0);
    chk("c.busy", 32'(busy), 32'd1);
    step();
    chk_wr("c.ph", 3'd3, 16'h0001);
    step();
    chk_wr("c.ctl", 3'd1, 16'h0007);
    step();
    chk_idle("c.run");
    chk("c.run.busy", 32'(busy), 32'd1);

    // Three serviced timeouts
    for (int i = 1; i <= 3; i++) begin
      irq_in = 1'b1;
      step();
      irq_in = 1'b0;
      chk_wr("irq.clr", 3'd0, 16'h0000);
      chk("irq.pulse", 32'(tick_pulse), 32'd1);
      chk("irq.count", tick_count, 32'(i));
      step();
      chk("irq.pulse_off", 32'(tick_pulse), 32'd0);
      chk_idle("irq.run");
      chk("irq.busy", 32'(busy), 32'd1);
      step();
    end

    // Snapshot: write snap_l, read 4, read 5, capture
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk_wr("snap.w", 3'd4, 16'h0000);
    step();
    chk_rd("snap.rl", 3'd4);
    step();
    chk_rd("snap.rh", 3'd5);
    m_readdata = 16'h1234;
    step();
    chk_idle("snap.cap");
    chk("snap.v_early", 32'(snapshot_valid), 32'd0);
    m_readdata = 16'h0056;
    step();
    m_readdata = 16'h0000;
    chk("snap.val", snapshot, 32'h0056_1234);
    chk("snap.v", 32'(snapshot_valid), 32'd1);
    step();
    chk("snap.v_off", 32'(snapshot_valid), 32'd0);
    chk("snap.hold", snapshot, 32'h0056_1234);

    // Stop and irq in the same RUN cycle: stop wins
    cfg_stop = 1'b1; irq_in = 1'b1;
    step();
    cfg_stop = 1'b0;
    chk_wr("stop.ctl", 3'd1, 16'h0008);
    chk("stop.pulse", 32'(tick_pulse), 32'd0);
    step();
    irq_in = 1'b0;
    chk_wr("stop.clr", 3'd0, 16'h0000);
    step();
    chk_idle("stop.idle");
    chk("stop.busy", 32'(busy), 32'd0);
    chk("stop.count", tick_count, 32'd3);

    // One-shot start and single timeout
    cfg_start = 1'b1; cfg_period = 32'h0000_0010; cfg_continuous = 1'b0;
    step();
    cfg_start = 1'b0;
    chk_wr("o.pl", 3'd2, 16'h0010);
    chk("o.count_clr", tick_count, 32'd0);
    step();
    chk_wr("o.ph", 3'd3, 16'h0000);
    step();
    chk_wr("o.ctl", 3'd1, 16'h0005);
    step();
    irq_in = 1'b1;
    step();
    irq_in = 1'b0;
    chk_wr("o.clr", 3'd0, 16'h0000);
    chk("o.pulse", 32'(tick_pulse), 32'd1);
    chk("o.count", tick_count, 32'd1);
    step();
    chk("o.busy", 32'(busy), 32'd0);
    chk_idle("o.idle");
    chk("o.count_hold", tick_count, 32'd1);

    // Zero period start is ignored
    cfg_start = 1'b1; cfg_period = 32'd0; cfg_continuous = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("z.busy", 32'(busy), 32'd0);
    chk_idle("z.bus");
    step();
    chk("z.busy2", 32'(busy), 32'd0);
    chk_idle("z.bus2");

    // Start and stop together in IDLE: start accepted, stop dropped
    cfg_start = 1'b1; cfg_stop = 1'b1; cfg_period = 32'h0002_0003; cfg_continuous = 1'b1;
    step();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    chk_wr("ss.pl", 3'd2, 16'h0003);
    chk("ss.busy", 32'(busy), 32'd1);
    step();
    chk_wr("ss.ph", 3'd3, 16'h0002);
    step();
    chk_wr("ss.ctl", 3'd1, 16'h0007);
    step();
    irq_in = 1'b1;
    step();
    irq_in = 1'b0;
    chk_wr("ss.clr", 3'd0, 16'h0000);
    chk("ss.pulse", 32'(tick_pulse), 32'd1);
    step();

    // Start while running is ignored
    cfg_start = 1'b1; cfg_period = 32'h0000_0005;
    step();
    cfg_start = 1'b0;
    chk_idle("rs.bus");
    chk("rs.busy", 32'(busy), 32'd1);
    chk("rs.count", tick_count, 32'd1);

    // Stop, restart, then reset during WR_PH
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    step();
    step();
    chk("rr.idle", 32'(busy), 32'd0);
    cfg_start = 1'b1; cfg_period = 32'h0007_0008;
    step();
    cfg_start = 1'b0;
    step();
    chk_wr("rr.ph", 3'd3, 16'h0007);
    reset_n = 1'b0;
    #1;
    chk("rr.cs", 32'(m_chipselect), 32'd0);
    chk("rr.wn", 32'(m_write_n), 32'd1);
    chk("rr.busy", 32'(busy), 32'd0);
    chk("rr.count", tick_count, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk_idle("rr.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_irq_master.md
Name: timer_irq_master

Overview:
- Avalon-MM initiator that programs and services a 16-bit-data interval timer slave on the system interconnect.
- The timer slave has a 3-bit word address, registered readdata and no waitrequest.
- On a start command the block writes the timer's period and control registers, then services each timeout IRQ by clearing status and counting ticks.
- It also performs snapshot reads on request, and stops the timer on command.
- Used by hardware sequencers that need a periodic tick without CPU involvement.

Parameters:
- ITO_EN, 1, value written to control bit0 (interrupt enable) at start; must be 1 for tick servicing.
- SNAP_EN, 1, 0 disables the snapshot sequence (snap_req ignored, snapshot outputs held at 0).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- cfg_start  in  1  pulse: program timer and start
- cfg_stop  in  1  pulse: stop timer
- cfg_period  in  32  timer period, sampled on accepted cfg_start
- cfg_continuous  in  1  1=periodic, 0=one-shot; sampled with cfg_period
- snap_req  in  1  pulse: capture counter snapshot
- busy  out  1  1 whenever FSM not IDLE
- tick_pulse  out  1  one-cycle pulse per serviced timeout
- tick_count  out  32  serviced timeouts since last accepted start, wraps
- snapshot  out  32  last captured counter value
- snapshot_valid  out  1  one-cycle pulse when snapshot updates
- m_address  out  3  timer word address
- m_chipselect  out  1  bus select
- m_write_n  out  1  active-low write
- m_writedata  out  16  write data
- m_readdata  in  16  read data, valid the cycle after a read cycle
- irq_in  in  1  timer irq, level, active-high

Behaviour:
- Clock and reset: clock clk; reset reset_n, asynchronous, active-low.
- Reset values: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, busy=0, tick_pulse=0, tick_count=0, snapshot=0, snapshot_valid=0, FSM=IDLE, pending flags=0.
- Timer register map (word addresses):
  - 0 status: bit0 TO, bit1 RUN; any write clears TO.
  - 1 control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2 period_l; 3 period_h.
  - 4 snap_l (any write latches counter); 5 snap_h.
- Bus cycles:
  - Every access is exactly one cycle with m_chipselect=1; write has m_write_n=0.
  - Read: m_write_n=1, m_readdata sampled on the following cycle.
  - Outputs are registered; idle bus has chipselect=0, write_n=1.
- FSM:
  - IDLE: cfg_start with cfg_period!=0 latches period and continuous, clears tick_count -> WR_PL. cfg_start with cfg_period==0 is ignored.
  - WR_PL: write addr2 = period[15:0] -> WR_PH.
  - WR_PH: write addr3 = period[31:16] -> WR_CTL.
  - WR_CTL: write addr1 = {0, 1, cont, ITO_EN}, i.e. 0x0007 when continuous, 0x0005 when one-shot -> RUN.
  - RUN priority order:
    1. stop_pend -> STOP_CTL.
    2. irq_in -> CLR_ST.
    3. snap_pend -> SNAP_W.
    4. Otherwise hold.
  - CLR_ST: write addr0 = 0; tick_pulse=1 this cycle; tick_count+1 (mod 2^32). Next state is RUN if continuous, else IDLE.
  - SNAP_W: write addr4 = 0 -> RD_L.
  - RD_L: read addr4 -> RD_H.
  - RD_H: read addr5; capture m_readdata into snapshot[15:0] -> CAP.
  - CAP: bus idle; capture m_readdata into snapshot[31:16]; snapshot_valid=1; clear snap_pend -> RUN.
  - STOP_CTL: write addr1 = 0x0008 -> STOP_CLR.
  - STOP_CLR: write addr0 = 0; clear stop_pend -> IDLE.
- Pending flags:
  - cfg_stop sets stop_pend in any state except IDLE. In IDLE it is ignored.
  - snap_req sets snap_pend in any non-IDLE state when SNAP_EN=1.
  - Both flags are cleared on entry to IDLE.
- cfg_start while not IDLE is ignored. No restart without an intervening stop or one-shot completion.
- Simultaneous cfg_start and cfg_stop in IDLE: start is accepted, the stop is ignored.
- irq_in asserted outside RUN is not serviced until RUN is re-entered; the level remains until CLR_ST.
- Snapshot sequence is atomic: an irq or stop arriving mid-sequence waits until RUN.
- Reset mid-operation returns all outputs to reset values immediately. The timer slave is not reprogrammed.
- Start-to-running latency: 3 bus cycles after the accepted cfg_start cycle. Snapshot latency: 4 cycles RUN-to-RUN.

Test Plan:
- Reset, then cfg_start with period=0x0001_86A0, continuous=1 -> three writes on consecutive cycles: (2,0x86A0), (3,0x0001), (1,0x0007); busy=1.
- In RUN, assert irq_in for 3 events -> each yields one write (0,0x0000), one tick_pulse, tick_count 1,2,3; FSM back in RUN.
- One-shot start (continuous=0), one irq_in -> control write 0x0005, then CLR_ST, tick_count=1, FSM IDLE, busy=0.
- snap_req in RUN with model returning 0x1234 (addr4) and 0x0056 (addr5) -> write (4,·), reads 4 then 5, snapshot=0x0056_1234, snapshot_valid one cycle.
- cfg_stop and irq_in in the same RUN cycle -> stop wins: writes (1,0x0008), (0,0x0000), IDLE, tick_count unchanged.
- cfg_period=0 start -> no bus activity, busy stays 0. Reset asserted during WR_PH -> chipselect=0 and busy=0 immediately.
